// File: rtl/project1_pkg.sv
// project1_pkg
//   Shared constants for the programmable 4-input Boolean function unit.
//   IDX_W      : width of the {a,b,c,d} truth-table index
//   TT_W       : width of the truth table (one bit per index value)
//   DEFAULT_TT : reset table, a 4-bit prime detector (2,3,5,7,11,13)
//   AND4_TT / OR4_TT / XOR4_TT : handy alternative tables
package project1_pkg;

  localparam int unsigned IDX_W = 4;
  localparam int unsigned TT_W  = 16;

  localparam logic [TT_W-1:0] DEFAULT_TT = 16'h28AC;
  localparam logic [TT_W-1:0] AND4_TT    = 16'h8000;
  localparam logic [TT_W-1:0] OR4_TT     = 16'hFFFE;
  localparam logic [TT_W-1:0] XOR4_TT    = 16'h6996;

endpackage

// File: rtl/project1_lut16.sv
// project1_lut16
//   Purely combinational 16:1 selector: f = tt[idx].
//   Ports:
//     tt  : in  [TT_W-1:0]  truth table, bit i is the result for index i
//     idx : in  [IDX_W-1:0] unsigned index
//     f   : out             selected truth-table bit
module project1_lut16
  import project1_pkg::*;
(
  input  logic [TT_W-1:0]  tt,
  input  logic [IDX_W-1:0] idx,
  output logic             f
);

  assign f = tt[idx];

endmodule

// File: rtl/project1_logic.sv
// project1_logic
//   Registered, programmable 4-input single-output Boolean function unit.
//   {a,b,c,d} (a = MSB) indexes a 16-bit truth table; the selected bit is
//   registered onto o. The table is rewritten in one cycle via cfg_we/cfg_tt.
//   Ports:
//     clk    : in   rising-edge clock
//     rst    : in   asynchronous active-high reset (o=0, table=TRUTH_TABLE)
//     a..d   : in   index bits 3..0
//     cfg_we : in   truth-table write enable
//     cfg_tt : in   [15:0] new truth table, captured when cfg_we=1
//     o      : out  registered function output
module project1_logic
  import project1_pkg::*;
#(
  parameter logic [TT_W-1:0] TRUTH_TABLE = DEFAULT_TT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a,
  input  logic            b,
  input  logic            c,
  input  logic            d,
  input  logic            cfg_we,
  input  logic [TT_W-1:0] cfg_tt,
  output logic            o
);

  logic [TT_W-1:0]  r_tt;
  logic             r_o;
  logic [IDX_W-1:0] w_idx;
  logic             w_f;

  assign w_idx = {a, b, c, d};

  project1_lut16 u_lut16 (
    .tt  (r_tt),
    .idx (w_idx),
    .f   (w_f)
  );

  // w_f is taken from the table before this edge's write lands, so a
  // simultaneous write only affects evaluation from the following edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tt <= TRUTH_TABLE;
      r_o  <= 1'b0;
    end else begin
      r_o <= w_f;
      if (cfg_we) begin
        r_tt <= cfg_tt;
      end
    end
  end

  assign o = r_o;

endmodule

// File: tb/tb_project1_logic.sv
// tb_project1_logic
//   Self-checking bench for project1_logic: table-driven sweeps, hand-written
//   reset/simultaneous-write sequences and randomized traffic against a
//   behavioural truth-table model.
module tb_project1_logic;

  logic        clk;
  logic        rst;
  logic        a, b, c, d;
  logic        cfg_we;
  logic [15:0] cfg_tt;
  logic        o;

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model: the current table as a plain bit array.
  bit m_tt [16];

  typedef struct {
    logic        we;
    logic [15:0] tt;
    logic [3:0]  idx;
    logic        exp;
  } vec_t;

  vec_t vecs[$];

  project1_logic dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .c      (c),
    .d      (d),
    .cfg_we (cfg_we),
    .cfg_tt (cfg_tt),
    .o      (o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

  function automatic logic is_prime(input int n);
    return (n == 2 || n == 3 || n == 5 || n == 7 || n == 11 || n == 13);
  endfunction

  function automatic logic parity4(input int n);
    return logic'((n % 2) + ((n / 2) % 2) + ((n / 4) % 2) + ((n / 8) % 2)) ;
  endfunction

  task automatic model_load(input logic [15:0] t);
    for (int i = 0; i < 16; i++) m_tt[i] = t[i];
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b required %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs, take one rising edge, update the model, settle 1ns.
  task automatic cyc(input logic we, input logic [15:0] t, input logic [3:0] idx,
                     output logic exp);
    {a, b, c, d} = idx;
    cfg_we = we;
    cfg_tt = t;
    @(posedge clk);
    exp = m_tt[idx];
    if (we) model_load(t);
    #1;
  endtask

  logic        e;
  logic [3:0]  ridx;
  logic [15:0] rtt;
  logic        rwe;

  initial begin
    rst = 1'b0; {a, b, c, d} = 4'b0; cfg_we = 1'b0; cfg_tt = 16'h0;
    model_load(16'h28AC);
    #1 rst = 1'b1;
    #1 check("reset_async_initial", o, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    check("reset_held", o, 1'b0);
    rst = 1'b0;

    // Release then one edge with abcd=0010.
    cyc(1'b0, 16'h0, 4'b0010, e);
    check("post_reset_0010", o, 1'b1);
    // Async assert mid-cycle while o=1.
    #2 rst = 1'b1;
    #1 check("reset_midcycle_async", o, 1'b0);
    rst = 1'b0;
    model_load(16'h28AC);
    cyc(1'b0, 16'h0, 4'b0010, e);
    check("release_0010", o, 1'b1);

    // Vector table: default sweep, AND4 write + sweep, XOR4 write + sweep.
    for (int i = 0; i < 16; i++)
      vecs.push_back('{1'b0, 16'($urandom), 4'(i), is_prime(i)});
    vecs.push_back('{1'b1, 16'h8000, 4'd0, 1'b0});
    for (int i = 0; i < 16; i++)
      vecs.push_back('{1'b0, 16'($urandom), 4'(i), logic'(i == 15)});
    vecs.push_back('{1'b1, 16'h6996, 4'd15, 1'b1});
    for (int i = 0; i < 16; i++)
      vecs.push_back('{1'b0, 16'($urandom), 4'(i), parity4(i)});
    vecs.push_back('{1'b1, 16'h28AC, 4'd7, 1'b1});

    foreach (vecs[k]) begin
      cyc(vecs[k].we, vecs[k].tt, vecs[k].idx, e);
      check($sformatf("vec%0d_idx%0d", k, vecs[k].idx), o, vecs[k].exp);
    end

    // Simultaneous write and evaluate: old table on this edge.
    cyc(1'b1, 16'h0000, 4'b0011, e);
    check("simul_old_table", o, 1'b1);
    cyc(1'b0, 16'h0000, 4'b0011, e);
    check("simul_new_table", o, 1'b0);

    // Reset mid-operation with a pending write.
    cyc(1'b1, 16'hFFFF, 4'b0000, e);
    check("ffff_write_edge", o, 1'b0);
    cyc(1'b0, 16'h0, 4'b0000, e);
    check("ffff_idx0", o, 1'b1);
    cfg_we = 1'b1; cfg_tt = 16'hFFFF;
    #2 rst = 1'b1;
    #1 check("midop_reset_async", o, 1'b0);
    @(posedge clk); #1;
    check("midop_reset_held", o, 1'b0);
    cfg_we = 1'b0;
    rst = 1'b0;
    model_load(16'h28AC);
    cyc(1'b0, 16'h0, 4'b0000, e);
    check("midop_table_restored_0", o, 1'b0);
    cyc(1'b0, 16'h0, 4'b1101, e);
    check("midop_table_restored_13", o, 1'b1);

    // Hold: cfg_we=0 with toggling cfg_tt.
    for (int i = 0; i < 16; i++) begin
      ridx = 4'($urandom);
      cyc(1'b0, 16'($urandom), ridx, e);
      check($sformatf("hold_%0d", i), o, is_prime(int'(ridx)));
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      rwe  = ($urandom_range(0, 3) == 0);
      rtt  = 16'($urandom);
      ridx = 4'($urandom);
      cyc(rwe, rtt, ridx, e);
      check($sformatf("rand_%0d", i), o, e);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
